// File: rtl/axa_pkg.sv
// Shared widths and SIG* error codes for the undo stack slice.
package axa_pkg;

    localparam int unsigned WORD  = 16;
    localparam int unsigned UPTR  = 4;
    localparam int unsigned USIZE = 16;

    typedef logic [WORD-1:0] word_t;

    localparam logic [3:0] SIGNONE = 4'd0;
    localparam logic [3:0] SIGLEX  = 4'd1;
    localparam logic [3:0] SIGOVF  = 4'd2;
    localparam logic [3:0] SIGILL  = 4'd3;

endpackage

// File: rtl/undo_ram.sv
// Undo buffer storage: DEPTH x WORD, one synchronous write port, two async read ports (pop, peek).
module undo_ram
    import axa_pkg::*;
#(
    parameter int unsigned DEPTH = USIZE,
    parameter int unsigned PW    = UPTR
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  word_t         wdata,
    input  logic [PW-1:0] raddr,
    output word_t         rdata,
    input  logic [PW-1:0] paddr,
    output word_t         pdata
);

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
    assign pdata = mem[paddr];

endmodule

// File: rtl/undo_stack_ctrl.sv
// Undo stack controller: push on forward execution, pop/peek on reverse execution.
// Define UNDO_OVF_TRAP_EN to refuse pushes while full and expose a sticky err_ovf flag.
module undo_stack_ctrl
    import axa_pkg::*;
#(
    parameter int unsigned DEPTH = USIZE,
    parameter int unsigned PW    = UPTR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    input  logic [15:0]   push_data,
    output logic          push_ready,
    input  logic          pop_valid,
    output logic          pop_ready,
    output logic [15:0]   pop_data,
    output logic          pop_data_valid,
    input  logic [PW-1:0] peek_off,
    output logic [15:0]   peek_data,
    input  logic          flush,
    output logic [PW-1:0] usp,
    output logic [PW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          err_lex,
`ifdef UNDO_OVF_TRAP_EN
    output logic          err_ovf,
`endif
    input  logic          err_clr
);

    localparam logic ST_RUN = 1'b0;
    localparam logic ST_ERR = 1'b1;

    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

    logic          state;
    logic          push_fire;
    logic          pop_fire;
    logic          pop_under;
    logic          ram_we;
    logic [PW-1:0] top_addr;
    logic [PW-1:0] peek_addr;
    word_t         ram_rdata;

    assign empty     = (count == '0);
    assign full      = (count == CNT_MAX);
    assign err_lex   = (state == ST_ERR);
    assign pop_ready = (state == ST_RUN);
`ifdef UNDO_OVF_TRAP_EN
    assign push_ready = !pop_valid && !full;
`else
    assign push_ready = !pop_valid;
`endif

    assign push_fire = push_valid && push_ready;
    assign pop_fire  = pop_valid && pop_ready && !empty;
    assign pop_under = pop_valid && empty;
    // Flush and reset both discard a same-cycle push, so the RAM write is gated too.
    assign ram_we    = push_fire && !flush && !reset;
    assign top_addr  = usp - PTR_ONE;
    assign peek_addr = usp - peek_off - PTR_ONE;

    undo_ram #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (usp),
        .wdata (push_data),
        .raddr (top_addr),
        .rdata (ram_rdata),
        .paddr (peek_addr),
        .pdata (peek_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            usp            <= '0;
            count          <= '0;
            state          <= ST_RUN;
            pop_data       <= '0;
            pop_data_valid <= 1'b0;
        end else if (flush) begin
            usp            <= '0;
            count          <= '0;
            state          <= ST_RUN;
            pop_data_valid <= 1'b0;
        end else begin
            pop_data_valid <= pop_fire;
            if (pop_fire) begin
                pop_data <= ram_rdata;
                usp      <= usp - PTR_ONE;
                count    <= count - CNT_ONE;
            end else if (push_fire) begin
                usp <= usp + PTR_ONE;
                if (!full) count <= count + CNT_ONE;
            end
            case (state)
                ST_RUN:  if (pop_under) state <= ST_ERR;
                default: if (err_clr)   state <= ST_RUN;
            endcase
        end
    end

`ifdef UNDO_OVF_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf <= 1'b0;
        end else if (flush) begin
            err_ovf <= 1'b0;
        end else if (push_valid && !pop_valid && full) begin
            err_ovf <= 1'b1;
        end else if (err_clr) begin
            err_ovf <= 1'b0;
        end
    end
`endif

endmodule
